// File: rtl/decode_stage_hs.sv
// RV32I/M decode stage with valid/ready handshake and a load scoreboard that stalls load-use hazards locally.
// Optional illegal-instruction flag: define DECODE_ILLEGAL_TRAP_EN to add illegal_o.
module decode_stage_hs #(
    parameter int XLEN     = 32,
    parameter int M_EXT    = 1,
    parameter int LOAD_LAT = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     inst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] reg_data1_i,
    input  logic [XLEN-1:0] reg_data2_i,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] rs1_o,
    output logic [XLEN-1:0] rs2_o,
    output logic [4:0]      rd_addr_o,
    output logic [4:0]      fwd_raddr1_o,
    output logic [4:0]      fwd_raddr2_o,
    output logic            rd_we_o,
    output logic            shiftsel_o,
    output logic            addsubsel_o,
    output logic            typesel_o,
    output logic            mem_re_o,
    output logic            mem_we_o,
    output logic [2:0]      opfunc3_o,
    output logic [2:0]      optype_o
`ifdef DECODE_ILLEGAL_TRAP_EN
   ,output logic            illegal_o
`endif
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] F7_ALT   = 7'b0100000;
    localparam logic [6:0] F7_MUL   = 7'b0000001;

    localparam logic [2:0] OT_R = 3'b000, OT_I = 3'b001, OT_B = 3'b010, OT_S = 3'b011;
    localparam logic [2:0] OT_U = 3'b100, OT_M = 3'b101, OT_J = 3'b110, OT_X = 3'b111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [4:0]      rd;
        logic [4:0]      ra1;
        logic [4:0]      ra2;
        logic            rd_we;
        logic            shiftsel;
        logic            addsubsel;
        logic            typesel;
        logic            mem_re;
        logic            mem_we;
        logic [2:0]      func3;
        logic [2:0]      optype;
`ifdef DECODE_ILLEGAL_TRAP_EN
        logic            illegal;
`endif
    } dec_t;

    dec_t dec_d, dec_q;
    logic valid_d, valid_q;
    logic rs1_used, rs2_used;
    logic hz_out, hz_sb;
    logic adv, accept;

    logic [6:0] opcode, funct7;
    assign opcode = inst_i[6:0];
    assign funct7 = inst_i[31:25];

    assign rs1_addr_o = inst_i[19:15];
    assign rs2_addr_o = inst_i[24:20];

    function automatic logic rs_hit(input logic [4:0] rd, input logic [4:0] a1, input logic [4:0] a2,
                                    input logic u1, input logic u2);
        return (rd != 5'd0) && ((u1 && (a1 == rd)) || (u2 && (a2 == rd)));
    endfunction

    always_comb begin
        dec_d           = '0;
        rs1_used        = 1'b0;
        rs2_used        = 1'b0;
        dec_d.pc        = pc_i;
        dec_d.rs1       = reg_data1_i;
        dec_d.rs2       = reg_data2_i;
        dec_d.rd        = inst_i[11:7];
        dec_d.ra1       = inst_i[19:15];
        dec_d.ra2       = inst_i[24:20];
        dec_d.func3     = inst_i[14:12];
        dec_d.optype    = OT_X;
        dec_d.shiftsel  = (funct7 == F7_ALT);
        dec_d.addsubsel = (opcode == OP_R) && (funct7 == F7_ALT) && (inst_i[14:12] == 3'b000);
        case (opcode)
            OP_R: begin
                dec_d.optype = ((funct7 == F7_MUL) && (M_EXT != 0)) ? OT_M : OT_R;
                dec_d.rd_we  = 1'b1;
                rs1_used     = 1'b1;
                rs2_used     = 1'b1;
            end
            OP_I: begin
                dec_d.optype = OT_I;
                dec_d.imm    = XLEN'($signed(inst_i[31:20]));
                dec_d.rd_we  = 1'b1;
                rs1_used     = 1'b1;
            end
            OP_L: begin
                dec_d.optype = OT_I;
                dec_d.imm    = XLEN'($signed(inst_i[31:20]));
                dec_d.rd_we  = 1'b1;
                dec_d.mem_re = 1'b1;
                rs1_used     = 1'b1;
            end
            OP_S: begin
                dec_d.optype = OT_S;
                dec_d.imm    = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
                dec_d.mem_we = 1'b1;
                rs1_used     = 1'b1;
                rs2_used     = 1'b1;
            end
            OP_B: begin
                dec_d.optype = OT_B;
                dec_d.imm    = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
                rs1_used     = 1'b1;
                rs2_used     = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                dec_d.optype  = OT_U;
                dec_d.imm     = XLEN'($signed({inst_i[31:12], 12'b0}));
                dec_d.rd_we   = 1'b1;
                dec_d.typesel = (opcode == OP_LUI);
            end
            OP_JAL: begin
                dec_d.optype  = OT_J;
                dec_d.imm     = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
                dec_d.rd_we   = 1'b1;
                dec_d.typesel = 1'b1;
            end
            OP_JALR: begin
                dec_d.optype = OT_J;
                dec_d.imm    = XLEN'($signed(inst_i[31:20]));
                dec_d.rd_we  = 1'b1;
                rs1_used     = 1'b1;
            end
            default: ;
        endcase
        if (dec_d.optype == OT_U) dec_d.func3 = 3'b000;
        if (dec_d.rd == 5'd0)     dec_d.rd_we = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        // An M opcode without M support is flagged but still decoded as R-type.
        dec_d.illegal = (dec_d.optype == OT_X) || ((opcode == OP_R) && (funct7 == F7_MUL) && (M_EXT == 0));
        if (dec_d.illegal) begin
            dec_d.rd_we  = 1'b0;
            dec_d.mem_re = 1'b0;
            dec_d.mem_we = 1'b0;
        end
`endif
    end

    assign hz_out = valid_q && dec_q.mem_re && rs_hit(dec_q.rd, inst_i[19:15], inst_i[24:20], rs1_used, rs2_used);

    // In-flight loads that have left decode but whose data is not yet forwardable.
    if (LOAD_LAT > 1) begin : g_sb
        logic                       push;
        logic [LOAD_LAT-2:0]        sb_v_q;
        logic [LOAD_LAT-2:0][4:0]   sb_rd_q;

        assign push = valid_q && ready_i && dec_q.mem_re && !flush_i;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sb_v_q  <= '0;
                sb_rd_q <= '0;
            end else begin
                sb_v_q[0]  <= push;
                sb_rd_q[0] <= push ? dec_q.rd : 5'd0;
                for (int k = 1; k < LOAD_LAT - 1; k++) begin
                    sb_v_q[k]  <= sb_v_q[k-1];
                    sb_rd_q[k] <= sb_rd_q[k-1];
                end
            end
        end

        always_comb begin
            hz_sb = 1'b0;
            for (int k = 0; k < LOAD_LAT - 1; k++) begin
                if (sb_v_q[k] && rs_hit(sb_rd_q[k], inst_i[19:15], inst_i[24:20], rs1_used, rs2_used))
                    hz_sb = 1'b1;
            end
        end
    end else begin : g_nosb
        assign hz_sb = 1'b0;
    end

    assign adv     = !valid_q || ready_i;
    assign ready_o = adv && !(hz_out || hz_sb) && !flush_i;
    assign accept  = valid_i && ready_o;

    always_comb begin
        valid_d = valid_q;
        if (flush_i)     valid_d = 1'b0;
        else if (accept) valid_d = 1'b1;
        else if (adv)    valid_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
        end else begin
            valid_q <= valid_d;
            if (accept) dec_q <= dec_d;
        end
    end

    assign valid_o      = valid_q;
    assign pc_o         = dec_q.pc;
    assign imm_o        = dec_q.imm;
    assign rs1_o        = dec_q.rs1;
    assign rs2_o        = dec_q.rs2;
    assign rd_addr_o    = dec_q.rd;
    assign fwd_raddr1_o = dec_q.ra1;
    assign fwd_raddr2_o = dec_q.ra2;
    assign rd_we_o      = dec_q.rd_we;
    assign shiftsel_o   = dec_q.shiftsel;
    assign addsubsel_o  = dec_q.addsubsel;
    assign typesel_o    = dec_q.typesel;
    assign mem_re_o     = dec_q.mem_re;
    assign mem_we_o     = dec_q.mem_we;
    assign opfunc3_o    = dec_q.func3;
    assign optype_o     = dec_q.optype;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign illegal_o    = dec_q.illegal;
`endif

endmodule

// File: tb/tb_decode_stage_hs.sv
// Scoreboard bench for decode_stage_hs (LOAD_LAT=3, M_EXT=1): driver queues expected outputs on accept, monitor checks transfers.
module tb_decode_stage_hs;

    typedef struct packed {
        logic [31:0] pc, imm, rs1, rs2;
        logic [4:0]  rd, a1, a2;
        logic        rd_we, shs, ads, ts, re, we;
        logic [2:0]  f3, ot;
        logic        ill;
    } exp_t;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] pc_i = '0, inst_i = '0;
    logic        valid_i = 1'b0, flush_i = 1'b0, ready_i = 1'b1;
    logic        ready_o, valid_o;
    logic [31:0] reg_data1_i, reg_data2_i;
    logic [4:0]  rs1_addr_o, rs2_addr_o;
    logic [31:0] pc_o, imm_o, rs1_o, rs2_o;
    logic [4:0]  rd_addr_o, fwd_raddr1_o, fwd_raddr2_o;
    logic        rd_we_o, shiftsel_o, addsubsel_o, typesel_o, mem_re_o, mem_we_o;
    logic [2:0]  opfunc3_o, optype_o;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        illegal_o;
`endif

    int   n_vec = 0, n_err = 0;
    exp_t exp_q[$];
    exp_t mon_e, mon_a;

    always #5 clk_i = ~clk_i;

    // Regfile model: read data tags the port and address.
    assign reg_data1_i = 32'hA000_0000 | {27'd0, rs1_addr_o};
    assign reg_data2_i = 32'hB000_0000 | {27'd0, rs2_addr_o};

    decode_stage_hs #(.XLEN(32), .M_EXT(1), .LOAD_LAT(3)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .pc_i(pc_i), .inst_i(inst_i), .valid_i(valid_i),
        .ready_o(ready_o), .reg_data1_i(reg_data1_i), .reg_data2_i(reg_data2_i),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .flush_i(flush_i), .valid_o(valid_o),
        .ready_i(ready_i), .pc_o(pc_o), .imm_o(imm_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .rd_addr_o(rd_addr_o), .fwd_raddr1_o(fwd_raddr1_o), .fwd_raddr2_o(fwd_raddr2_o),
        .rd_we_o(rd_we_o), .shiftsel_o(shiftsel_o), .addsubsel_o(addsubsel_o),
        .typesel_o(typesel_o), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o),
        .opfunc3_o(opfunc3_o), .optype_o(optype_o)
`ifdef DECODE_ILLEGAL_TRAP_EN
       ,.illegal_o(illegal_o)
`endif
    );

    function automatic exp_t E(input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] a1,
                               input logic [4:0] a2, input logic [4:0] rd, input logic [5:0] ctl,
                               input logic [2:0] f3, input logic [2:0] ot, input logic ill);
        exp_t e;
        e.pc = pc; e.imm = imm;
        e.rs1 = 32'hA000_0000 | {27'd0, a1};
        e.rs2 = 32'hB000_0000 | {27'd0, a2};
        e.rd = rd; e.a1 = a1; e.a2 = a2;
        {e.rd_we, e.shs, e.ads, e.ts, e.re, e.we} = ctl;
        e.f3 = f3; e.ot = ot; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t cur_out();
        exp_t a;
        a.pc = pc_o; a.imm = imm_o; a.rs1 = rs1_o; a.rs2 = rs2_o;
        a.rd = rd_addr_o; a.a1 = fwd_raddr1_o; a.a2 = fwd_raddr2_o;
        {a.rd_we, a.shs, a.ads, a.ts, a.re, a.we} =
            {rd_we_o, shiftsel_o, addsubsel_o, typesel_o, mem_re_o, mem_we_o};
        a.f3 = opfunc3_o; a.ot = optype_o;
`ifdef DECODE_ILLEGAL_TRAP_EN
        a.ill = illegal_o;
`else
        a.ill = 1'b0;
`endif
        return a;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present one instruction; count cycles ready_o is low before acceptance.
    task automatic send(input logic [31:0] ins, input logic [31:0] pc, input exp_t e, output int waits);
        bit ok;
        ok = 0; waits = 0;
        inst_i = ins; pc_i = pc; valid_i = 1'b1;
        while (!ok && waits <= 20) begin
            @(negedge clk_i);
            if (ready_o) begin
                ok = 1;
                exp_q.push_back(e);
            end else waits++;
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
    endtask

    task automatic sx(input string nm, input logic [31:0] ins, input logic [31:0] pc, input exp_t e,
                      input int want);
        int w;
        send(ins, pc, e, w);
        chk(nm, w, want);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && valid_o && ready_i) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL out_unexpected: got pc %h with nothing expected", pc_o);
            end else begin
                mon_e = exp_q.pop_front();
                mon_a = cur_out();
                if (mon_a !== mon_e) begin
                    n_err++;
                    $display("FAIL out_pc%h: got %h expected %h", mon_e.pc, mon_a, mon_e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wy;
        repeat (2) @(negedge clk_i);
        chk("rst0_valid", valid_o, 0);
        chk("rst0_outs", (cur_out() === '0) ? 32'd1 : 32'd0, 1);
        @(posedge clk_i); #1 rst_ni = 1'b1;
        idle(1);

        // Back-to-back stream, one per cycle
        sx("st_addi", 32'h00500093, 32'h100, E(32'h100, 32'd5,         0,  5, 1,  6'b100000, 3'b000, 3'b001, 0), 0);
        sx("st_add",  32'h00108133, 32'h104, E(32'h104, 32'd0,         1,  1, 2,  6'b100000, 3'b000, 3'b000, 0), 0);
        sx("st_sub",  32'h401101B3, 32'h108, E(32'h108, 32'd0,         2,  1, 3,  6'b111000, 3'b000, 3'b000, 0), 0);
        sx("st_lui",  32'h12345437, 32'h10C, E(32'h10C, 32'h12345000,  8,  3, 8,  6'b100100, 3'b000, 3'b100, 0), 0);
        sx("st_addn", 32'hFFF08493, 32'h110, E(32'h110, 32'hFFFFFFFF,  1, 31, 9,  6'b100000, 3'b000, 3'b001, 0), 0);
        sx("st_beq",  32'hFE208CE3, 32'h114, E(32'h114, 32'hFFFFFFF8,  1,  2, 25, 6'b000000, 3'b000, 3'b010, 0), 0);
        sx("st_jal",  32'h010000EF, 32'h118, E(32'h118, 32'd16,        0, 16, 1,  6'b100100, 3'b000, 3'b110, 0), 0);
        sx("st_mul",  32'h022081B3, 32'h11C, E(32'h11C, 32'd0,         1,  2, 3,  6'b100000, 3'b000, 3'b101, 0), 0);
        sx("st_unk",  32'h0000037F, 32'h120, E(32'h120, 32'd0,         0,  0, 6,  6'b000000, 3'b000, 3'b111, ILL_EN), 0);
        idle(2);

        // Back-pressure: output held for 3 cycles, next accepted once ready_i returns
        ready_i = 1'b0;
        sx("bp_x", 32'h00500093, 32'h200, E(32'h200, 32'd5, 0, 5, 1, 6'b100000, 3'b000, 3'b001, 0), 0);
        fork
            send(32'h00108133, 32'h204, E(32'h204, 32'd0, 1, 1, 2, 6'b100000, 3'b000, 3'b000, 0), wy);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk_i);
                    chk("bp_valid", valid_o, 1);
                    chk("bp_pc", pc_o, 32'h200);
                    chk("bp_imm", imm_o, 32'd5);
                    chk("bp_ready", ready_o, 0);
                end
                @(posedge clk_i); #1 ready_i = 1'b1;
            end
        join
        chk("bp_y_wait", wy, 3);

        // Load-use with LOAD_LAT=3: three bubbles on rs1 and on rs2 dependence; none for rd=x0
        sx("lu_lw",   32'h0080A283, 32'h300, E(32'h300, 32'd8,  1, 8, 5,  6'b100010, 3'b010, 3'b001, 0), 0);
        sx("lu_add",  32'h00028333, 32'h304, E(32'h304, 32'd0,  5, 0, 6,  6'b100000, 3'b000, 3'b000, 0), 3);
        sx("lu_lw2",  32'h0080A283, 32'h308, E(32'h308, 32'd8,  1, 8, 5,  6'b100010, 3'b010, 3'b001, 0), 0);
        sx("lu_sw",   32'h0050A623, 32'h30C, E(32'h30C, 32'd12, 1, 5, 12, 6'b000001, 3'b010, 3'b011, 0), 3);
        sx("lu_lw0",  32'h00412003, 32'h310, E(32'h310, 32'd4,  2, 4, 0,  6'b000010, 3'b010, 3'b001, 0), 0);
        sx("lu_add0", 32'h00000333, 32'h314, E(32'h314, 32'd0,  0, 0, 6,  6'b100000, 3'b000, 3'b000, 0), 0);

        // Flush with a load in the output register and a dependent at the input
        sx("fl_lw", 32'h0080A283, 32'h400, E(32'h400, 32'd8, 1, 8, 5, 6'b100010, 3'b010, 3'b001, 0), 0);
        inst_i = 32'h00028333; pc_i = 32'h404; valid_i = 1'b1; flush_i = 1'b1;
        @(negedge clk_i);
        chk("fl_ready_lo", ready_o, 0);
        @(posedge clk_i); #1 flush_i = 1'b0;
        @(negedge clk_i);
        chk("fl_valid", valid_o, 0);
        chk("fl_ready_hi", ready_o, 1);
        if (ready_o) exp_q.push_back(E(32'h404, 32'd0, 5, 0, 6, 6'b100000, 3'b000, 3'b000, 0));
        @(posedge clk_i); #1 valid_i = 1'b0;
        idle(3);

        // Asynchronous reset mid-stream with a load in the scoreboard
        sx("rs_lw",   32'h0080A283, 32'h600, E(32'h600, 32'd8, 1, 8, 5, 6'b100010, 3'b010, 3'b001, 0), 0);
        sx("rs_addi", 32'h00500093, 32'h604, E(32'h604, 32'd5, 0, 5, 1, 6'b100000, 3'b000, 3'b001, 0), 0);
        #1 rst_ni = 1'b0;
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_imm", imm_o, 0);
        chk("rst_rd", rd_addr_o, 0);
        chk("rst_outs", (cur_out() === '0) ? 32'd1 : 32'd0, 1);
        exp_q.delete();
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;
        sx("rs_add", 32'h00028333, 32'h608, E(32'h608, 32'd0, 5, 0, 6, 6'b100000, 3'b000, 3'b000, 0), 0);

        idle(5);
        chk("queue_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
